// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU execution unit.
// Optional macro ALU_DIV_EN enables the iterative unsigned divider (opcode 8).
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SLL = 4'd5,
        OP_SRL = 4'd6,
        OP_MUL = 4'd7,
        OP_DIV = 4'd8
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_ITER = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Opcodes that run through the multi-cycle iterative datapath
    function automatic logic is_iter_op(input logic [3:0] op);
`ifdef ALU_DIV_EN
        return (op == OP_MUL) || (op == OP_DIV);
`else
        return (op == OP_MUL);
`endif
    endfunction

    // Assemble the NZCV nibble in its architectural bit order
    function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative shift-add multiplier; with ALU_DIV_EN also a restoring divider.
// start_i loads the operands, one step runs per cycle for CYCLES cycles, and
// done_o is high for the single cycle in which acc_o holds the final value.
// Multiply: acc_o = full 2*WIDTH product. Divide: acc_o = {remainder, quotient}.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int CYCLES = WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
`ifdef ALU_DIV_EN
    input  logic               div_i,
`endif
    input  logic [WIDTH-1:0]   op_a_i,
    input  logic [WIDTH-1:0]   op_b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] acc_o
);

    localparam int CW = $clog2(CYCLES + 1);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               run_q, run_d;
    logic               div_q, div_d;
    logic               div_req;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     rem;

`ifdef ALU_DIV_EN
    assign div_req = div_i;
`else
    assign div_req = 1'b0;
`endif

    // Step control and one multiply/divide iteration per cycle
    always_comb begin
        acc_d = acc_q;
        opa_d = opa_q;
        cnt_d = cnt_q;
        run_d = run_q;
        div_d = div_q;
        sum   = '0;
        rem   = '0;
        if (start_i) begin
            run_d = 1'b1;
            cnt_d = '0;
            div_d = div_req;
            if (div_req) begin
                // divisor kept aside, dividend shifted up through the low half
                opa_d = op_b_i;
                acc_d = {{WIDTH{1'b0}}, op_a_i};
            end else begin
                // multiplicand kept aside, multiplier consumed from the low half
                opa_d = op_a_i;
                acc_d = {{WIDTH{1'b0}}, op_b_i};
            end
        end else if (run_q) begin
            if (cnt_q == CW'(CYCLES)) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CW'(1);
                if (div_q) begin
                    rem = acc_q[2*WIDTH-1:WIDTH-1];
                    if (rem >= {1'b0, opa_q}) begin
                        rem   = rem - {1'b0, opa_q};
                        acc_d = {rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                            (acc_q[0] ? {1'b0, opa_q} : '0);
                    acc_d = {sum, acc_q[WIDTH-1:1]};
                end
            end
        end
    end

    // Iteration state; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            opa_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
            div_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            opa_q <= opa_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
            div_q <= div_d;
        end
    end

    assign done_o = run_q && (cnt_q == CW'(CYCLES));
    assign acc_o  = acc_q;

endmodule

// File: rtl/alu_exec_unit.sv
// 32-bit integer execution unit with valid/ready command and result handshakes.
// Single-cycle ops go IDLE->EXEC->DONE; MUL (and DIV when ALU_DIV_EN is
// defined) go IDLE->ITER->DONE through the iterative datapath.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH      = ALU_WIDTH,
    parameter int MUL_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       Flags,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    state_e             state_q, state_d;
    opcode_e            opc_q;
    logic [WIDTH-1:0]   op1_q, op2_q;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [3:0]         flags_q, flags_d;

    logic               accept;
    logic               it_start;
    logic               it_done;
    logic [2*WIDTH-1:0] it_acc;

    logic [SHW-1:0]     shamt;
    logic [WIDTH:0]     exec_wide;
    logic [WIDTH-1:0]   exec_res;
    logic               exec_c, exec_v;
    logic [3:0]         exec_flg;
    logic [WIDTH-1:0]   iter_res;
    logic               iter_c, iter_v;
    logic [3:0]         iter_flg;

    assign accept   = in_valid && (state_q == ST_IDLE);
    assign it_start = accept && is_iter_op(opcode);
    assign shamt    = op2_q[SHW-1:0];

    alu_iter_muldiv #(
        .WIDTH  (WIDTH),
        .CYCLES (MUL_CYCLES)
    ) u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (it_start),
`ifdef ALU_DIV_EN
        .div_i   (opcode == OP_DIV),
`endif
        .op_a_i  (operand1),
        .op_b_i  (operand2),
        .done_o  (it_done),
        .acc_o   (it_acc)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: one command in flight, result must drain before next accept
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = is_iter_op(opcode) ? ST_ITER : ST_EXEC;
            ST_EXEC: state_d = ST_DONE;
            ST_ITER: if (it_done) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q != ST_IDLE);
    end

    // Command latch; inputs are only sampled on an accepted handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opc_q <= OP_ADD;
            op1_q <= '0;
            op2_q <= '0;
        end else if (accept) begin
            opc_q <= opcode_e'(opcode);
            op1_q <= operand1;
            op2_q <= operand2;
        end
    end

    // Single-cycle datapath evaluated on the latched command
    always_comb begin
        exec_wide = '0;
        exec_res  = '0;
        exec_c    = 1'b0;
        exec_v    = 1'b0;
        case (opc_q)
            OP_ADD: begin
                exec_wide = {1'b0, op1_q} + {1'b0, op2_q};
                exec_res  = exec_wide[WIDTH-1:0];
                exec_c    = exec_wide[WIDTH];
                exec_v    = (op1_q[WIDTH-1] == op2_q[WIDTH-1]) &&
                            (exec_res[WIDTH-1] != op1_q[WIDTH-1]);
            end
            OP_SUB: begin
                // top bit of the widened difference is the borrow
                exec_wide = {1'b0, op1_q} - {1'b0, op2_q};
                exec_res  = exec_wide[WIDTH-1:0];
                exec_c    = ~exec_wide[WIDTH];
                exec_v    = (op1_q[WIDTH-1] != op2_q[WIDTH-1]) &&
                            (exec_res[WIDTH-1] != op1_q[WIDTH-1]);
            end
            OP_AND: exec_res = op1_q & op2_q;
            OP_OR:  exec_res = op1_q | op2_q;
            OP_XOR: exec_res = op1_q ^ op2_q;
            OP_SLL: begin
                // extra guard bit above catches the last bit shifted out
                exec_wide = {1'b0, op1_q} << shamt;
                exec_res  = exec_wide[WIDTH-1:0];
                exec_c    = exec_wide[WIDTH];
            end
            OP_SRL: begin
                // extra guard bit below catches the last bit shifted out
                exec_wide = {op1_q, 1'b0} >> shamt;
                exec_res  = exec_wide[WIDTH:1];
                exec_c    = exec_wide[0];
            end
            default: ;  // illegal opcode: zero result, flags reduce to Z only
        endcase
        exec_flg = pack_flags(exec_res[WIDTH-1], exec_res == '0, exec_c, exec_v);
    end

    // Final result and flags from the iterative datapath
    always_comb begin
        iter_res = it_acc[WIDTH-1:0];
        iter_c   = |it_acc[2*WIDTH-1:WIDTH];
        iter_v   = |it_acc[2*WIDTH-1:WIDTH];
`ifdef ALU_DIV_EN
        if (opc_q == OP_DIV) begin
            if (op2_q == '0) begin
                iter_res = '1;
                iter_c   = 1'b0;
                iter_v   = 1'b1;
            end else begin
                iter_v   = 1'b0;
            end
        end
`endif
        iter_flg = pack_flags(iter_res[WIDTH-1], iter_res == '0, iter_c, iter_v);
    end

    // Result capture; held unchanged while waiting in DONE
    always_comb begin
        result_d = result_q;
        flags_d  = flags_q;
        if (state_q == ST_EXEC) begin
            result_d = exec_res;
            flags_d  = exec_flg;
        end else if ((state_q == ST_ITER) && it_done) begin
            result_d = iter_res;
            flags_d  = iter_flg;
        end
    end

    // Result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign Result = result_q;
    assign Flags  = flags_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
`timescale 1ns/1ps
module tb_alu_exec_unit;

    localparam int MULC = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [3:0]  opcode = 4'd0;
    logic [31:0] operand1 = 32'd0;
    logic [31:0] operand2 = 32'd0;
    logic        in_ready, out_valid, busy;
    logic [31:0] Result;
    logic [3:0]  Flags;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rdy_mode = 1;      // 0 random, 1 high, 2 held low
    bit junk_en  = 1'b0;
    bit chk_en   = 1'b0;

    typedef struct {
        logic [31:0] r;
        logic [3:0]  f;
        int          due;
        bit          seen;
    } exp_t;
    exp_t exp_q[$];

    alu_exec_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .operand1  (operand1),
        .operand2  (operand2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .Flags     (Flags),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: {Result, N, Z, C, V} straight from the arithmetic definitions
    function automatic logic [35:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] w;
        logic [31:0] r;
        logic        c, v;
        longint      s;
        int          sh;
        w = '0; r = '0; c = 1'b0; v = 1'b0; s = 0;
        sh = int'(b[4:0]);
        case (op)
            4'd0: begin
                w = 64'(a) + 64'(b); r = w[31:0]; c = w[32];
                s = longint'($signed(a)) + longint'($signed(b));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd1: begin
                r = a - b; c = (a >= b);
                s = longint'($signed(a)) - longint'($signed(b));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: begin w = 64'(a) << sh; r = w[31:0]; c = w[32]; end
            4'd6: begin w = {a, 32'd0} >> sh; r = w[63:32]; c = w[31]; end
            4'd7: begin w = 64'(a) * 64'(b); r = w[31:0]; c = (w[63:32] != 0); v = c; end
`ifdef ALU_DIV_EN
            4'd8: begin
                if (b == 0) begin r = 32'hFFFF_FFFF; v = 1'b1; end
                else begin r = a / b; c = ((a % b) != 0); end
            end
`endif
            default: r = '0;
        endcase
        return {r, r[31], (r == 32'd0), c, v};
    endfunction

    function automatic bit is_iter(input logic [3:0] op);
`ifdef ALU_DIV_EN
        return (op == 4'd7) || (op == 4'd8);
`else
        return (op == 4'd7);
`endif
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 65535));
            default: return $urandom;
        endcase
    endfunction

    // Compare process: every cycle a result is presented it must match the model
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("in_ready_is_not_busy", in_ready, !busy);
            if (exp_q.size() == 0) begin
                chk("no_spurious_result", out_valid, 1'b0);
            end else if (out_valid) begin
                chk("result", Result, exp_q[0].r);
                chk("flags", Flags, exp_q[0].f);
                chk("in_ready_low_in_done", in_ready, 1'b0);
                if (!exp_q[0].seen) begin
                    chk("result_latency", cyc, exp_q[0].due);
                    exp_q[0].seen = 1'b1;
                end
                if (out_ready) void'(exp_q.pop_front());
            end else if (cyc > exp_q[0].due) begin
                chk("result_latency_late", cyc, exp_q[0].due);
                void'(exp_q.pop_front());
            end
        end
    end

    // Issue one command, queue its expectation and wait for it to drain
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit lit, input logic [31:0] lr, input logic [3:0] lf,
                         output int acc_cyc, output int held);
        exp_t        e;
        logic [35:0] m;
        int          w;
        held = 0;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 300) begin @(negedge clk); w++; end
        if (!in_ready) begin
            chk("accept_timeout", in_ready, 1'b1);
            acc_cyc = -1;
            return;
        end
        in_valid = 1'b1; opcode = op; operand1 = a; operand2 = b;
        @(posedge clk); #1;
        in_valid = 1'b0; operand1 = $urandom; operand2 = $urandom;
        m = model(op, a, b);
        e.r = lit ? lr : m[35:4];
        e.f = lit ? lf : m[3:0];
        e.due = cyc + (is_iter(op) ? MULC + 1 : 1);
        e.seen = 1'b0;
        exp_q.push_back(e);
        acc_cyc = cyc;
        w = 0;
        while (exp_q.size() != 0 && w < 400) begin
            @(posedge clk); #2;
            if (rdy_mode == 2 && out_valid) begin
                held++;
                if (held >= 5) rdy_mode = 1;
            end
            case (rdy_mode)
                0: out_ready = 1'($urandom_range(0, 1));
                1: out_ready = 1'b1;
                default: out_ready = 1'b0;
            endcase
            if (junk_en && busy && !out_valid) begin
                in_valid = 1'($urandom_range(0, 1));
                opcode = 4'($urandom_range(0, 15));
                operand1 = $urandom; operand2 = $urandom;
            end else begin
                in_valid = 1'b0;
            end
            w++;
        end
        in_valid = 1'b0;
        if (exp_q.size() != 0) begin
            chk("completion_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, h, w;
        logic [3:0] op;

        // Hand-derived values pinning the reference model
        chk("pin_add_ovf",   model(4'd0, 32'h7FFF_FFFF, 32'h1), {32'h8000_0000, 4'b1001});
        chk("pin_sub_zero",  model(4'd1, 32'h5, 32'h5), {32'h0, 4'b0110});
        chk("pin_sub_borrow", model(4'd1, 32'h0, 32'h1), {32'hFFFF_FFFF, 4'b1000});
        chk("pin_sll",       model(4'd5, 32'h8000_0001, 32'h21), {32'h2, 4'b0010});
        chk("pin_srl",       model(4'd6, 32'h0000_0003, 32'h1), {32'h1, 4'b0010});
        chk("pin_mul",       model(4'd7, 32'h1_0000, 32'h1_0000), {32'h0, 4'b0111});
        chk("pin_illegal",   model(4'hF, 32'h1234, 32'h5678), {32'h0, 4'b0100});
`ifdef ALU_DIV_EN
        chk("pin_div",       model(4'd8, 32'd100, 32'd7), {32'd14, 4'b0010});
        chk("pin_div0",      model(4'd8, 32'd55, 32'd0), {32'hFFFF_FFFF, 4'b1001});
`endif

        // Reset state while reset is asserted and right after release
        #1;
        chk("rst_result", Result, 32'd0);
        chk("rst_flags", Flags, 4'd0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1'b1);
        chk("post_rst_out_valid", out_valid, 1'b0);
        chk_en = 1'b1;
        rdy_mode = 1;

        // Directed cases with literal expectations
        do_op(4'd0, 32'h7FFF_FFFF, 32'h1, 1'b1, 32'h8000_0000, 4'b1001, a0, h);
        do_op(4'd1, 32'h5, 32'h5, 1'b1, 32'h0, 4'b0110, a0, h);
        do_op(4'd1, 32'h0, 32'h1, 1'b1, 32'hFFFF_FFFF, 4'b1000, a1, h);
        chk("throughput_3_cycles", a1 - a0, 3);
        do_op(4'd5, 32'h8000_0001, 32'h21, 1'b1, 32'h2, 4'b0010, a0, h);
        do_op(4'd6, 32'h8000_0001, 32'h0, 1'b1, 32'h8000_0001, 4'b1000, a0, h);
        do_op(4'hF, 32'hDEAD_BEEF, 32'h1, 1'b1, 32'h0, 4'b0100, a0, h);
`ifdef ALU_DIV_EN
        do_op(4'd8, 32'd100, 32'd7, 1'b1, 32'd14, 4'b0010, a0, h);
        do_op(4'd8, 32'hDEAD_BEEF, 32'd0, 1'b1, 32'hFFFF_FFFF, 4'b1001, a0, h);
`else
        do_op(4'd8, 32'd100, 32'd7, 1'b1, 32'h0, 4'b0100, a0, h);
`endif
        rdy_mode = 2;
        do_op(4'd7, 32'h1_0000, 32'h1_0000, 1'b1, 32'h0, 4'b0111, a0, h);
        chk("mul_held_cycles", h, 5);
        rdy_mode = 1;

        // Reset in the middle of a multiply
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 100) begin @(negedge clk); w++; end
        in_valid = 1'b1; opcode = 4'd7; operand1 = 32'h1234_5678; operand2 = 32'h9ABC_DEF0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_mul_busy", busy, 1'b1);
        chk("mid_mul_out_valid", out_valid, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_result", Result, 32'd0);
        chk("abort_flags", Flags, 4'd0);
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(4'd0, 32'd3, 32'd4, 1'b1, 32'd7, 4'b0000, a0, h);

        // Randomized traffic against the model, with junk commands while busy
        rdy_mode = 0;
        junk_en = 1'b1;
        repeat (80) begin
            if ($urandom_range(0, 4) == 0) op = 4'($urandom_range(8, 15));
            else op = 4'($urandom_range(0, 7));
            do_op(op, rnd_operand(), rnd_operand(), 1'b0, 32'd0, 4'd0, a0, h);
        end
        junk_en = 1'b0;
        in_valid = 1'b0;
        rdy_mode = 1;
        repeat (4) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
